// File: rtl/slc3_pkg.sv
// -----------------------------------------------------------------------------
// slc3_pkg
//   Shared definitions for the SLC-3 board I/O bridge.
//
//   pause_state_t     : states of the ISDU pause/continue responder
//   IO_ADDR_DEFAULT   : memory-mapped switch / hex-display register address
//   seg7()            : hex nibble to active-low seven-segment pattern,
//                       bit order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package slc3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAUSED = 2'd1,
    ACK    = 2'd2
  } pause_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Cleans up one active-low board push-button: two-flop synchronizer,
//   counter-based debounce, and a one-cycle pulse on each accepted press.
//
//   Ports
//     clk      in   system clock
//     reset    in   synchronous, active-high reset
//     btn_raw  in   raw button level, pressed = 0
//     pulse    out  single-cycle pulse per accepted press (1 -> 0 of the
//                   debounced level); releases produce nothing
//
//   Raw fall to pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge register) cycles.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  // The counter only needs to hold DEBOUNCE_CYCLES-1: the cycle in which it
  // would reach DEBOUNCE_CYCLES is the cycle the level flips and it clears.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      // Registered edge detect adds the final cycle of latency and keeps the
      // pulse glitch-free for the downstream FSM.
      pulse   <= level_d & ~level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/slc3_io_bridge.sv
// -----------------------------------------------------------------------------
// slc3_io_bridge
//   Board-side responder for the SLC-3 user interface. Conditions the Run and
//   Continue buttons, synchronizes the switches, serves the memory-mapped
//   switch / hex-display register, and answers the ISDU pause handshake.
//
//   Pause FSM
//     state  | meaning
//     IDLE   | CPU running; a pause request latches its code onto LED
//     PAUSED | CPU waiting; a Continue press moves on to ACK
//     ACK    | pause_ack high until the ISDU drops pause_req
//   A Run press from any state returns to IDLE with LED cleared.
//
//   Ports
//     Clk, Reset           clock, synchronous active-high reset
//     Run, Continue        raw active-low buttons
//     SW[9:0]              raw switches
//     run_pulse            one-cycle pulse per accepted Run press
//     continue_pulse       one-cycle pulse per accepted Continue press
//     mem_addr/ce/we/wdata CPU memory bus (MAR, enables, MDR)
//     io_hit               combinational mem_addr == IO_ADDR
//     io_rdata[15:0]       registered {6'b0, synced SW}
//     pause_req/pause_code ISDU pause request and LED value
//     pause_ack            ISDU may leave its pause state
//     LED[9:0]             pause LED register
//     HEX0..HEX3           active-low seven-segment, hex_reg nibbles 0..3
// -----------------------------------------------------------------------------
module slc3_io_bridge
  import slc3_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 3,
  parameter logic [15:0] IO_ADDR         = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [9:0]  SW,
  output logic        run_pulse,
  output logic        continue_pulse,
  input  logic [15:0] mem_addr,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [15:0] mem_wdata,
  output logic        io_hit,
  output logic [15:0] io_rdata,
  input  logic        pause_req,
  input  logic [9:0]  pause_code,
  output logic        pause_ack,
  output logic [9:0]  LED,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  logic [9:0]   sw_s1;
  logic [9:0]   sw_s2;
  logic [15:0]  hex_reg;
  pause_state_t state;
  pause_state_t state_nxt;
  logic [9:0]   led_nxt;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_btn (
    .clk    (Clk),
    .reset  (Reset),
    .btn_raw(Run),
    .pulse  (run_pulse)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_continue_btn (
    .clk    (Clk),
    .reset  (Reset),
    .btn_raw(Continue),
    .pulse  (continue_pulse)
  );

  assign io_hit = (mem_addr == IO_ADDR);

  // io_rdata is reloaded every cycle regardless of mem_ce, so reads carry no
  // side effects and the register simply trails the switches by 3 cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      io_rdata <= '0;
      hex_reg  <= '0;
    end else begin
      sw_s1    <= SW;
      sw_s2    <= sw_s1;
      io_rdata <= {6'b0, sw_s2};
      if (mem_ce && mem_we && io_hit) begin
        hex_reg <= mem_wdata;
      end
    end
  end

  assign HEX0 = seg7(hex_reg[3:0]);
  assign HEX1 = seg7(hex_reg[7:4]);
  assign HEX2 = seg7(hex_reg[11:8]);
  assign HEX3 = seg7(hex_reg[15:12]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      LED   <= '0;
    end else begin
      state <= state_nxt;
      LED   <= led_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    led_nxt   = LED;
    pause_ack = 1'b0;
    if (run_pulse) begin
      // CPU restart overrides any handshake in progress.
      state_nxt = IDLE;
      led_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          // continue_pulse is deliberately not looked at here, so a pulse
          // coinciding with the request cannot skip the PAUSED state.
          if (pause_req) begin
            state_nxt = PAUSED;
            led_nxt   = pause_code;
          end
        end
        PAUSED: begin
          if (continue_pulse) begin
            state_nxt = ACK;
          end
        end
        ACK: begin
          pause_ack = 1'b1;
          if (!pause_req) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_io_bridge.sv
module tb_slc3_io_bridge;

  localparam int DB        = 3;
  localparam int PULSE_LAT = 2 + DB + 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Run = 1'b1;
  logic        Continue = 1'b1;
  logic [9:0]  SW = '0;
  logic        run_pulse;
  logic        continue_pulse;
  logic [15:0] mem_addr = '0;
  logic        mem_ce = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_wdata = '0;
  logic        io_hit;
  logic [15:0] io_rdata;
  logic        pause_req = 1'b0;
  logic [9:0]  pause_code = '0;
  logic        pause_ack;
  logic [9:0]  LED;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int run_cnt = 0;
  int cont_cnt = 0;
  int cont_last = 0;

  logic [6:0]  seg_ref [16];
  logic [15:0] m_hex;
  logic [9:0]  m_sw;

  slc3_io_bridge #(.DEBOUNCE_CYCLES(DB), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .SW(SW),
    .run_pulse(run_pulse), .continue_pulse(continue_pulse),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .io_hit(io_hit), .io_rdata(io_rdata),
    .pause_req(pause_req), .pause_code(pause_code), .pause_ack(pause_ack),
    .LED(LED), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 Clk = ~Clk;

  // Observe pulses shortly after each rising edge.
  always @(posedge Clk) begin
    cyc++;
    #1;
    if (continue_pulse === 1'b1) begin
      cont_cnt++;
      cont_last = cyc;
    end
    if (run_pulse === 1'b1) run_cnt++;
  end

  function automatic logic [27:0] hex_expect(input logic [15:0] v);
    return {seg_ref[v[15:12]], seg_ref[v[11:8]], seg_ref[v[7:4]], seg_ref[v[3:0]]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press_btn(input bit is_run, input int hold);
    if (is_run) Run = 1'b0; else Continue = 1'b0;
    step(hold);
    if (is_run) Run = 1'b1; else Continue = 1'b1;
    step(PULSE_LAT + 2);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    step(2);
    tests++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {4{7'b1000000}}) begin
      fails++; $display("FAIL reset_hex got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0}, {4{7'b1000000}});
    end
    tests++;
    if (LED !== 10'd0) begin fails++; $display("FAIL reset_led got=%h exp=0", LED); end
    tests++;
    if (pause_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", pause_ack); end
    tests++;
    if (io_rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", io_rdata); end
    tests++;
    if ({run_pulse, continue_pulse} !== 2'b00) begin
      fails++; $display("FAIL reset_pulses got=%b exp=00", {run_pulse, continue_pulse});
    end
    Reset = 1'b0;
    m_hex = 16'h0;
    m_sw  = SW;
    step(2);
  endtask

  task automatic test_debounce_glitch;
    for (int k = 0; k < 4; k++) begin
      int c;
      int len;
      c   = cont_cnt;
      len = (k == 0) ? 2 : int'($urandom_range(1, DB - 1));
      Continue = 1'b0;
      step(len);
      Continue = 1'b1;
      step(PULSE_LAT + 4);
      tests++;
      if (cont_cnt !== c) begin
        fails++; $display("FAIL glitch_len%0d pulses got=%0d exp=0", len, cont_cnt - c);
      end
    end
  endtask

  task automatic test_debounce_press;
    int c;
    int c0;
    int r;
    c  = cont_cnt;
    c0 = cyc;
    Continue = 1'b0;
    step(10);
    tests++;
    if (cont_cnt !== c + 1) begin
      fails++; $display("FAIL press_one_pulse got=%0d exp=1", cont_cnt - c);
    end
    tests++;
    if (cont_last - c0 !== PULSE_LAT) begin
      fails++; $display("FAIL press_latency got=%0d exp=%0d", cont_last - c0, PULSE_LAT);
    end
    step(10);
    tests++;
    if (cont_cnt !== c + 1) begin
      fails++; $display("FAIL hold_one_pulse got=%0d exp=1", cont_cnt - c);
    end
    Continue = 1'b1;
    step(12);
    tests++;
    if (cont_cnt !== c + 1) begin
      fails++; $display("FAIL release_no_pulse got=%0d exp=1", cont_cnt - c);
    end
    for (int k = 0; k < 4; k++) begin
      int hold;
      hold = int'($urandom_range(DB, 12));
      r = run_cnt;
      press_btn(1'b1, hold);
      tests++;
      if (run_cnt !== r + 1) begin
        fails++; $display("FAIL run_press_hold%0d got=%0d exp=1", hold, run_cnt - r);
      end
    end
  endtask

  task automatic test_hex_write;
    mem_addr = 16'hFFFF; mem_wdata = 16'h1234; mem_ce = 1'b1; mem_we = 1'b1;
    step(1);
    mem_ce = 1'b0; mem_we = 1'b0;
    m_hex = 16'h1234;
    tests++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}) begin
      fails++; $display("FAIL hex_1234 got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0},
                        {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    end
    mem_addr = 16'hFFFE; mem_wdata = 16'hFFFF; mem_ce = 1'b1; mem_we = 1'b1;
    #1;
    tests++;
    if (io_hit !== 1'b0) begin fails++; $display("FAIL io_hit_fffe got=%b exp=0", io_hit); end
    step(1);
    mem_ce = 1'b0; mem_we = 1'b0;
    tests++;
    if ({HEX3, HEX2, HEX1, HEX0} !== hex_expect(m_hex)) begin
      fails++; $display("FAIL hex_other_addr got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0}, hex_expect(m_hex));
    end
    for (int k = 0; k < 12; k++) begin
      logic [15:0] a;
      logic [15:0] d;
      logic        ce;
      logic        we;
      a  = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
      d  = 16'($urandom);
      ce = 1'($urandom);
      we = 1'($urandom);
      mem_addr = a; mem_wdata = d; mem_ce = ce; mem_we = we;
      #1;
      tests++;
      if (io_hit !== (a == 16'hFFFF)) begin
        fails++; $display("FAIL io_hit_rand addr=%h got=%b exp=%b", a, io_hit, (a == 16'hFFFF));
      end
      step(1);
      mem_ce = 1'b0; mem_we = 1'b0;
      if (ce && we && a == 16'hFFFF) m_hex = d;
      tests++;
      if ({HEX3, HEX2, HEX1, HEX0} !== hex_expect(m_hex)) begin
        fails++; $display("FAIL hex_rand addr=%h ce=%b we=%b got=%h exp=%h", a, ce, we,
                          {HEX3, HEX2, HEX1, HEX0}, hex_expect(m_hex));
      end
    end
  endtask

  task automatic test_sw_read;
    logic [9:0] nsw;
    mem_addr = 16'hFFFF; mem_ce = 1'b1; mem_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nsw = (k == 0) ? 10'b0000001011 : 10'($urandom);
      SW = nsw;
      step(2);
      tests++;
      if (io_rdata !== {6'b0, m_sw}) begin
        fails++; $display("FAIL sw_early got=%h exp=%h", io_rdata, {6'b0, m_sw});
      end
      step(1);
      m_sw = nsw;
      tests++;
      if (io_rdata !== {6'b0, m_sw} || io_hit !== 1'b1) begin
        fails++; $display("FAIL sw_read got=%h hit=%b exp=%h hit=1", io_rdata, io_hit, {6'b0, m_sw});
      end
    end
    mem_ce = 1'b0;
    tests++;
    if ({HEX3, HEX2, HEX1, HEX0} !== hex_expect(m_hex)) begin
      fails++; $display("FAIL read_side_effect got=%h exp=%h", {HEX3, HEX2, HEX1, HEX0}, hex_expect(m_hex));
    end
  endtask

  task automatic test_pause;
    bit bad;
    bit got;
    int c0;
    pause_code = 10'h001; pause_req = 1'b1;
    step(1);
    tests++;
    if (LED !== 10'h001) begin fails++; $display("FAIL pause1_led got=%h exp=001", LED); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (pause_ack !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL pause1_ack_early got=1 exp=0"); end
    c0 = cyc;
    Continue = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (pause_ack === 1'b1) begin got = 1'b1; break; end
    end
    tests++;
    if (!got || cyc - c0 !== PULSE_LAT + 1) begin
      fails++; $display("FAIL pause1_ack_latency got=%0d seen=%b exp=%0d", cyc - c0, got, PULSE_LAT + 1);
    end
    Continue = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (pause_ack !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL pause1_ack_hold got=0 exp=1"); end
    pause_req = 1'b0;
    step(1);
    tests++;
    if (pause_ack !== 1'b0 || LED !== 10'h001) begin
      fails++; $display("FAIL pause1_release ack=%b led=%h exp ack=0 led=001", pause_ack, LED);
    end
    step(3);
    pause_code = 10'h002; pause_req = 1'b1;
    step(1);
    tests++;
    if (LED !== 10'h002) begin fails++; $display("FAIL pause2_led got=%h exp=002", LED); end
    press_btn(1'b0, 8);
    tests++;
    if (pause_ack !== 1'b1) begin fails++; $display("FAIL pause2_ack got=%b exp=1", pause_ack); end
    pause_req = 1'b0;
    step(2);
    tests++;
    if (pause_ack !== 1'b0) begin fails++; $display("FAIL pause2_done got=%b exp=0", pause_ack); end

    // Continue pulse coincides with the cycle the request is first seen.
    Continue = 1'b0;
    step(PULSE_LAT);
    tests++;
    if (continue_pulse !== 1'b1) begin
      fails++; $display("FAIL same_cycle_setup pulse got=%b exp=1", continue_pulse);
    end
    pause_code = 10'($urandom_range(1, 1023)); pause_req = 1'b1;
    step(1);
    tests++;
    if (LED !== pause_code) begin fails++; $display("FAIL same_cycle_led got=%h exp=%h", LED, pause_code); end
    Continue = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (pause_ack !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL same_cycle_ignored ack got=1 exp=0"); end
    pause_req = 1'b0;
  endtask

  task automatic test_run_abort;
    bit bad;
    bit got;
    press_btn(1'b1, 6);
    pause_code = 10'h005; pause_req = 1'b1;
    step(1);
    pause_req = 1'b0;
    tests++;
    if (LED !== 10'h005) begin fails++; $display("FAIL abort_setup_led got=%h exp=005", LED); end
    step(3);
    Run = 1'b0;
    step(PULSE_LAT + 1);
    tests++;
    if (LED !== 10'h0 || pause_ack !== 1'b0) begin
      fails++; $display("FAIL run_abort led=%h ack=%b exp led=000 ack=0", LED, pause_ack);
    end
    Run = 1'b1;
    step(PULSE_LAT + 2);
    Continue = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < PULSE_LAT + 10; i++) begin
      step(1);
      if (pause_ack !== 1'b0) bad = 1'b1;
    end
    Continue = 1'b1;
    step(PULSE_LAT + 2);
    tests++;
    if (bad) begin fails++; $display("FAIL run_abort_no_ack got=1 exp=0"); end

    // Reset while PAUSED.
    pause_code = 10'($urandom_range(1, 1023)); pause_req = 1'b1;
    step(1);
    pause_req = 1'b0;
    step(2);
    Reset = 1'b1;
    step(1);
    tests++;
    if (LED !== 10'h0 || pause_ack !== 1'b0 || io_rdata !== 16'h0 ||
        {HEX3, HEX2, HEX1, HEX0} !== {4{7'b1000000}}) begin
      fails++; $display("FAIL reset_paused led=%h ack=%b rdata=%h hex=%h exp all reset", LED, pause_ack,
                        io_rdata, {HEX3, HEX2, HEX1, HEX0});
    end
    Reset = 1'b0;
    m_hex = 16'h0;
    step(2);
    Continue = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < PULSE_LAT + 10; i++) begin
      step(1);
      if (pause_ack !== 1'b0) bad = 1'b1;
    end
    Continue = 1'b1;
    step(PULSE_LAT + 2);
    tests++;
    if (bad) begin fails++; $display("FAIL reset_paused_no_ack got=1 exp=0"); end

    // Reset while in ACK.
    pause_code = 10'h3A5; pause_req = 1'b1;
    step(1);
    Continue = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (pause_ack === 1'b1) begin got = 1'b1; break; end
    end
    tests++;
    if (!got) begin fails++; $display("FAIL ack_setup timeout got=0 exp=1"); end
    Reset = 1'b1;
    step(1);
    tests++;
    if (LED !== 10'h0 || pause_ack !== 1'b0) begin
      fails++; $display("FAIL reset_ack led=%h ack=%b exp led=000 ack=0", LED, pause_ack);
    end
    Reset = 1'b0;
    pause_req = 1'b0;
    Continue = 1'b1;
    step(PULSE_LAT + 2);
  endtask

  initial begin
    seg_ref[0]  = 7'b1000000; seg_ref[1]  = 7'b1111001;
    seg_ref[2]  = 7'b0100100; seg_ref[3]  = 7'b0110000;
    seg_ref[4]  = 7'b0011001; seg_ref[5]  = 7'b0010010;
    seg_ref[6]  = 7'b0000010; seg_ref[7]  = 7'b1111000;
    seg_ref[8]  = 7'b0000000; seg_ref[9]  = 7'b0010000;
    seg_ref[10] = 7'b0001000; seg_ref[11] = 7'b0000011;
    seg_ref[12] = 7'b1000110; seg_ref[13] = 7'b0100001;
    seg_ref[14] = 7'b0000110; seg_ref[15] = 7'b0001110;
    m_hex = 16'h0;
    m_sw  = 10'h0;
    test_reset();
    test_debounce_glitch();
    test_debounce_press();
    test_hex_write();
    test_sw_read();
    test_pause();
    test_run_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
